spi_shifter_gen: RTL

Parametrised full-duplex SPI shift engine, successor to the fixed 8-bit shifter in the APB-SPI controller.
- Supports DATA_WIDTH-bit frames with a runtime frame length and LSB/MSB-first ordering.
- Adds explicit busy/done/abort/overrun signalling.
- Sits between the APB register file (tx load, rx data) and the baud/SCLK generator, which supplies the per-edge send/receive strobes.

---
 rtl/spi_shifter_pkg.sv | 22 ++
 rtl/spi_bit_counter.sv | 33 +++
 rtl/spi_shifter_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_shifter_pkg.sv
// spi_shifter_pkg: shared types and helpers for the SPI shift engine.
//   state_e  - shift engine states (IDLE, LOADED, XFER, DONE)
//   eff_len  - effective frame length: 0 or anything above the data width
//              selects the full data width
package spi_shifter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    XFER,
    DONE
  } state_e;

  function automatic int unsigned eff_len(input int unsigned frame_len,
                                          input int unsigned data_width);
    if (frame_len == 0 || frame_len > data_width) begin
      return data_width;
    end
    return frame_len;
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: saturating bit counter with terminal compare.
//   PCLK    - system clock
//   PRESET  - asynchronous active-high reset
//   clr_i   - synchronous clear (wins over inc_i)
//   inc_i   - increment request; ignored once the count equals len_i
//   len_i   - terminal count
//   cnt_o   - current count
//   term_o  - cnt_o == len_i
module spi_bit_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] len_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  assign term_o = (cnt_o == len_i);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && !term_o) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_shifter_gen.sv
// spi_shifter_gen: parametrised full-duplex SPI shift engine.
//   PCLK, PRESET            - clock, asynchronous active-high reset
//   ss_i                    - slave select, active low; rising mid-frame aborts
//   load_i, tx_data_i       - start a frame with the given right-aligned word
//   frame_len_i             - bits per frame (0 or > DATA_WIDTH = DATA_WIDTH)
//   lsbfe_i, cpha_i, cpol_i - bit order and SPI mode, latched at load
//   mosi_send_sclk*_i       - send strobes from the SCLK generator
//   miso_receive_sclk*_i    - receive strobes from the SCLK generator
//   miso_i / mosi_o         - serial data in / out
//   rx_data_o, rx_valid_o   - last completed received word and its update pulse
//   busy_o                  - frame pending or in progress
//   abort_o, overrun_o      - one-cycle event pulses
// Build option SPI_SHIFTER_LOOPBACK_EN adds loopback_i, which makes the
// receive path sample mosi_o instead of miso_i.
module spi_shifter_gen
  import spi_shifter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  ss_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic [CNT_W-1:0]      frame_len_i,
  input  logic                  lsbfe_i,
  input  logic                  cpha_i,
  input  logic                  cpol_i,
  input  logic                  mosi_send_sclk_i,
  input  logic                  mosi_send_sclk0_i,
  input  logic                  miso_receive_sclk_i,
  input  logic                  miso_receive_sclk0_i,
`ifdef SPI_SHIFTER_LOOPBACK_EN
  input  logic                  loopback_i,
`endif
  input  logic                  miso_i,
  output logic                  mosi_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  abort_o,
  output logic                  overrun_o
);

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [CNT_W-1:0]      len_q;
  logic [CNT_W-1:0]      len_eff;
  logic                  lsbfe_q, cpha_q, cpol_q;

  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic             tx_term, rx_term;
  logic [CNT_W-1:0] tx_idx;
  logic             tx_bit, rx_bit;

  logic sel0, send_strb, rcv_strb;
  logic start, go, abort, tx_fire, rx_fire, cnt_clr;

  assign len_eff = CNT_W'(eff_len(32'(frame_len_i), DATA_WIDTH));

  assign sel0      = cpha_q ^ cpol_q;
  assign send_strb = sel0 ? mosi_send_sclk0_i    : mosi_send_sclk_i;
  assign rcv_strb  = sel0 ? miso_receive_sclk0_i : miso_receive_sclk_i;

  assign start   = (state_q == IDLE) && load_i;
  assign go      = (state_q == LOADED) && !ss_i;
  assign abort   = ((state_q == LOADED) || (state_q == XFER)) && ss_i;
  // cpha=0 preloads the first bit on LOADED->XFER; that preload counts as a send.
  assign tx_fire = (go && !cpha_q) ||
                   ((state_q == XFER) && !ss_i && send_strb && !tx_term);
  assign rx_fire = (state_q == XFER) && !ss_i && rcv_strb && !rx_term;
  assign cnt_clr = start || abort || (state_q == DONE);

  assign busy_o = (state_q != IDLE);

  assign tx_idx = lsbfe_q ? tx_cnt : (len_q - CNT_W'(1) - tx_cnt);
  assign tx_bit = |(tx_q & (DATA_WIDTH'(1) << tx_idx));

`ifdef SPI_SHIFTER_LOOPBACK_EN
  assign rx_bit = loopback_i ? mosi_o : miso_i;
`else
  assign rx_bit = miso_i;
`endif

  // rx_sr starts cleared, so bits at or above L stay zero in both orders.
  always_comb begin
    rx_next = rx_sr;
    if (lsbfe_q) begin
      rx_next = rx_sr | (DATA_WIDTH'(rx_bit) << rx_cnt);
    end else begin
      rx_next = {rx_sr[DATA_WIDTH-2:0], rx_bit};
    end
  end

  spi_bit_counter #(.CNT_W(CNT_W)) u_tx_cnt (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .clr_i  (cnt_clr),
    .inc_i  (tx_fire),
    .len_i  (len_q),
    .cnt_o  (tx_cnt),
    .term_o (tx_term)
  );

  spi_bit_counter #(.CNT_W(CNT_W)) u_rx_cnt (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .clr_i  (cnt_clr),
    .inc_i  (rx_fire),
    .len_i  (len_q),
    .cnt_o  (rx_cnt),
    .term_o (rx_term)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_i) state_d = LOADED;
      LOADED:  state_d = ss_i ? IDLE : XFER;
      XFER: begin
        if (ss_i) begin
          state_d = IDLE;
        end else if (rx_term) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_q       <= '0;
      rx_sr      <= '0;
      len_q      <= '0;
      lsbfe_q    <= 1'b0;
      cpha_q     <= 1'b0;
      cpol_q     <= 1'b0;
      mosi_o     <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      abort_o    <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      abort_o    <= 1'b0;
      overrun_o  <= load_i && (state_q != IDLE);

      if (start) begin
        tx_q    <= tx_data_i;
        len_q   <= len_eff;
        lsbfe_q <= lsbfe_i;
        cpha_q  <= cpha_i;
        cpol_q  <= cpol_i;
        rx_sr   <= '0;
      end

      if (abort) begin
        abort_o <= 1'b1;
        mosi_o  <= 1'b0;
      end else if (tx_fire) begin
        mosi_o <= tx_bit;
      end

      if (rx_fire) begin
        rx_sr <= rx_next;
      end

      if (state_q == DONE) begin
        rx_data_o  <= rx_sr;
        rx_valid_o <= 1'b1;
        mosi_o     <= 1'b0;
      end
    end
  end

endmodule
